multicycle_control_unit: RTL and testbench
==========================================

Name:
multicycle_control_unit

Overview:
- Multicycle successor to the single-cycle MIPS control decoder.
- Sequences each instruction through fetch/decode/execute/memory/writeback states, one state per clock.
- Shares one memory port through a mem_req/mem_ready handshake, so variable-latency memory is supported.
- Drives the multicycle datapath muxes, enables and ALU control; ALU control width is parametrised.

Parameters:
- ALU_CTRL_W, 3: width of alu_control; 3-bit codes are zero-extended to this width; must be >=3.
- RESET_STATE_FETCH, 1: 1 = leave reset in FETCH; 0 = leave reset in IDLE and wait one cycle before FETCH.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
op  in  6  instruction opcode, valid from the IR after FETCH completes
funct  in  6  R-type function field
zero  in  1  ALU zero flag
mem_ready  in  1  memory accepted/completed the current request
mem_req  out  1  memory access request
mem_write  out  1  request is a write
iord  out  1  memory address source: 0 = PC, 1 = ALUOut
ir_write  out  1  instruction register load enable
pc_en  out  1  PC load enable: pc_write | (branch & zero)
reg_write  out  1  register file write enable
reg_dst  out  1  destination: 0 = rt, 1 = rd
mem_to_reg  out  1  writeback source: 0 = ALUOut, 1 = MDR
alu_src_a  out  1  ALU A source: 0 = PC, 1 = A register
alu_src_b  out  2  ALU B source: 00 = B, 01 = 4, 10 = signext imm, 11 = signext imm<<2
alu_control  out  ALU_CTRL_W  ALU operation
pc_src  out  2  next PC: 00 = ALU, 01 = ALUOut, 10 = jump target
instr_done  out  1  one-cycle pulse in the final state of each instruction

Behaviour:
- Reset (async, rst=1): state = FETCH (or IDLE when RESET_STATE_FETCH=0); all outputs 0.
- Outputs are Moore (decoded from the state register), except enables gated by mem_ready as noted below.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu add.
  - ir_write and pc_write assert only in the cycle where mem_ready=1; that same cycle transitions to DECODE.
  - If mem_ready=0, hold in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu add (branch target). Next state by op:
  - lw/sw (100011/101011) -> MEMADR
  - R-type (000000) -> EXECUTE
  - beq (000100) -> BRANCH
  - addi (001000) -> ADDIEXEC
  - j (000010) -> JUMP
  - any other op -> FETCH (treated as nop, instr_done=1)
- MEMADR: alu_src_a=1, alu_src_b=10, add. Next MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: mem_req=1, iord=1. Hold until mem_ready, then MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1 -> FETCH.
- MEMWRITE: mem_req=1, mem_write=1, iord=1. Hold until mem_ready; instr_done=1 on the ready cycle -> FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_control from funct:
  - add 100000 -> 010, sub 100010 -> 110, and 100100 -> 000, or 100101 -> 001, slt 101010 -> 111
  - any other funct -> 010
  - next ALUWB
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, branch=1, pc_src=01, instr_done=1 -> FETCH. pc_en = zero.
- ADDIEXEC: alu_src_a=1, alu_src_b=10, add -> ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, instr_done=1 -> FETCH.
- JUMP: pc_write=1, pc_src=10, instr_done=1 -> FETCH.
- Latency: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3 cycles, each plus memory wait cycles.
- mem_ready is ignored in every state that does not assert mem_req.
- Reset mid-operation returns to the reset state immediately; no partial writes occur after rst rises.
- op and funct are sampled only in DECODE and EXECUTE respectively; the IR holds them stable.

Optional Feature:
- Macro: MCU_ILLEGAL_TRAP_EN.
- Defined: adds output port trap (1 bit) and state TRAP.
  - An undefined op in DECODE, or an undefined funct in EXECUTE, goes to TRAP instead of proceeding.
  - TRAP holds trap=1 with all other outputs 0 until reset.
- Undefined: no trap port; undefined op and funct behave as specified above (nop / add).

Decomposition:
- Package mcu_pkg: state enum, opcode constants, funct constants, 3-bit ALU operation codes, alu_src_b and pc_src encodings.
- Sub-module alu_decoder: combinational funct + alu_op(2) -> alu_control, reusable by the single-cycle control path.

Test Plan:
- Reset with op=000000, mem_ready=1, rst released: all outputs 0 during reset; FETCH next cycle with mem_req=1, ir_write=1, pc_en=1.
- lw (op=100011), mem_ready=1 throughout: FETCH, DECODE, MEMADR, MEMREAD, MEMWB in 5 cycles; MEMWB shows reg_write=1, mem_to_reg=1, instr_done=1.
- sw with mem_ready held 0 for 3 cycles in MEMWRITE: state held with mem_req=1, mem_write=1; instr_done only on the ready cycle; total 7 cycles.
- beq run twice, zero=1 then zero=0: pc_en=1 then pc_en=0 in BRANCH, pc_src=01 both times.
- R-type funct=101010: alu_control=111 in EXECUTE; ALUWB shows reg_dst=1; funct=111111 gives 010 (trap=1 when MCU_ILLEGAL_TRAP_EN is defined).
- rst asserted mid-MEMREAD: outputs drop to 0 asynchronously; no reg_write occurs; restart in FETCH.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit: FSM states,
// opcode/funct constants, 3-bit ALU codes and datapath mux encodings.
package mcu_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTE, S_ALUWB, S_BRANCH, S_ADDIEXEC, S_ADDIWB, S_JUMP, S_TRAP
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // alu_op selects between fixed add/sub and funct-driven decoding
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic op_known(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decoder: alu_op plus funct -> 3-bit ALU code.
// funct_valid_o flags an unrecognised funct when alu_op requests funct decoding.
module alu_decoder
  import mcu_pkg::*;
(
  input  logic [5:0] funct_i,
  input  logic [1:0] alu_op_i,
  output logic [2:0] alu_control_o,
  output logic       funct_valid_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    funct_valid_o = 1'b1;
    case (alu_op_i)
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alu_control_o = ALU_ADD;
          FN_SUB:  alu_control_o = ALU_SUB;
          FN_AND:  alu_control_o = ALU_AND;
          FN_OR:   alu_control_o = ALU_OR;
          FN_SLT:  alu_control_o = ALU_SLT;
          default: funct_valid_o = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM sharing one memory port via mem_req/mem_ready.
// Define MCU_ILLEGAL_TRAP_EN to add the trap output and a sticky TRAP state.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int ALU_CTRL_W        = 3,
  parameter bit RESET_STATE_FETCH = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            op,
  input  logic [5:0]            funct,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic                  iord,
  output logic                  ir_write,
  output logic                  pc_en,
  output logic                  reg_write,
  output logic                  reg_dst,
  output logic                  mem_to_reg,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [1:0]            pc_src,
  output logic                  instr_done
`ifdef MCU_ILLEGAL_TRAP_EN
  ,
  output logic                  trap
`endif
);

`ifdef MCU_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam state_e RESET_STATE = RESET_STATE_FETCH ? S_FETCH : S_IDLE;

  state_e     state_q;
  logic       is_load_q;
  logic [1:0] alu_op;
  logic [2:0] alu_ctrl3;
  logic       funct_valid;
  logic       alu_active;
  logic       pc_write;
  logic       branch;

  alu_decoder u_alu_decoder (
    .funct_i       (funct),
    .alu_op_i      (alu_op),
    .alu_control_o (alu_ctrl3),
    .funct_valid_o (funct_valid)
  );

  // lw/sw choice is captured in DECODE so op is only looked at there
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RESET_STATE;
      is_load_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE:   state_q <= S_FETCH;
        S_FETCH:  if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          is_load_q <= (op == OP_LW);
          case (op)
            OP_LW, OP_SW: state_q <= S_MEMADR;
            OP_RTYPE:     state_q <= S_EXECUTE;
            OP_BEQ:       state_q <= S_BRANCH;
            OP_ADDI:      state_q <= S_ADDIEXEC;
            OP_J:         state_q <= S_JUMP;
            default:      state_q <= TRAP_EN ? S_TRAP : S_FETCH;
          endcase
        end
        S_MEMADR:   state_q <= is_load_q ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (mem_ready) state_q <= S_MEMWB;
        S_MEMWRITE: if (mem_ready) state_q <= S_FETCH;
        S_EXECUTE:  state_q <= (TRAP_EN && !funct_valid) ? S_TRAP : S_ALUWB;
        S_ADDIEXEC: state_q <= S_ADDIWB;
        S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_q <= S_FETCH;
        S_TRAP:     state_q <= S_TRAP;
        default:    state_q <= RESET_STATE;
      endcase
    end
  end

  // Moore decode; held at zero while rst is high so nothing leaks during reset
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    pc_src     = PCSRC_ALU;
    instr_done = 1'b0;
    alu_op     = ALUOP_ADD;
    alu_active = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = SRCB_FOUR;
          alu_active = 1'b1;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_b  = SRCB_IMM_SH2;
          alu_active = 1'b1;
          instr_done = !TRAP_EN && !op_known(op);
        end
        S_MEMADR, S_ADDIEXEC: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_IMM;
          alu_active = 1'b1;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req    = 1'b1;
          mem_write  = 1'b1;
          iord       = 1'b1;
          instr_done = mem_ready;
        end
        S_EXECUTE: begin
          alu_src_a  = 1'b1;
          alu_op     = ALUOP_FUNCT;
          alu_active = 1'b1;
        end
        S_ALUWB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = ALUOP_SUB;
          alu_active = 1'b1;
          branch     = 1'b1;
          pc_src     = PCSRC_ALUOUT;
          instr_done = 1'b1;
        end
        S_ADDIWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_src     = PCSRC_JUMP;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pc_en       = pc_write | (branch & zero);
  assign alu_control = alu_active ? ALU_CTRL_W'(alu_ctrl3) : '0;

`ifdef MCU_ILLEGAL_TRAP_EN
  assign trap = !rst && (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomised self-checking bench for multicycle_control_unit; expected per-cycle
// outputs are built from the instruction-level step list of each opcode.
module tb_multicycle_control_unit;

`ifdef MCU_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef struct packed {
    logic       trap;
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       src_a;
    logic [1:0] src_b;
    logic [2:0] alu;
    logic [1:0] pc_src;
    logic       done;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       mem_req, mem_write, iord, ir_write, pc_en, reg_write, reg_dst;
  logic       mem_to_reg, alu_src_a, instr_done, trap_w;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  vec_t       obs;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_en(pc_en), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .pc_src(pc_src), .instr_done(instr_done)
`ifdef MCU_ILLEGAL_TRAP_EN
    , .trap(trap_w)
`endif
  );

`ifndef MCU_ILLEGAL_TRAP_EN
  assign trap_w = 1'b0;
`endif

  always_comb begin
    obs = '{trap_w, mem_req, mem_write, iord, ir_write, pc_en, reg_write, reg_dst,
            mem_to_reg, alu_src_a, alu_src_b, alu_control, pc_src, instr_done};
  end

  function automatic logic [2:0] exp_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic bit funct_ok(input logic [5:0] f);
    return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  // Expected cycle-by-cycle outputs for one instruction plus the mem_ready to drive.
  task automatic run_instr(input logic [5:0] op_v, input logic [5:0] funct_v,
                           input logic zero_v, input int fwait, input int mwait,
                           input string tag);
    vec_t exp_q[$];
    bit   rdy_q[$];
    vec_t v, dec;
    bit   is_sw;
    is_sw = (op_v == 6'b101011);
    v = '0; v.mem_req = 1; v.src_b = 2'b01; v.alu = 3'b010;
    repeat (fwait) begin exp_q.push_back(v); rdy_q.push_back(1'b0); end
    v.ir_write = 1; v.pc_en = 1;
    exp_q.push_back(v); rdy_q.push_back(1'b1);
    dec = '0; dec.src_b = 2'b11; dec.alu = 3'b010;
    case (op_v)
      6'b100011, 6'b101011: begin
        exp_q.push_back(dec); rdy_q.push_back(1'($urandom_range(0, 1)));
        v = '0; v.src_a = 1; v.src_b = 2'b10; v.alu = 3'b010;
        exp_q.push_back(v); rdy_q.push_back(1'($urandom_range(0, 1)));
        v = '0; v.mem_req = 1; v.iord = 1; v.mem_write = is_sw;
        repeat (mwait) begin exp_q.push_back(v); rdy_q.push_back(1'b0); end
        v.done = is_sw;
        exp_q.push_back(v); rdy_q.push_back(1'b1);
        if (!is_sw) begin
          v = '0; v.reg_write = 1; v.mem_to_reg = 1; v.done = 1;
          exp_q.push_back(v); rdy_q.push_back(1'($urandom_range(0, 1)));
        end
      end
      6'b000000: begin
        exp_q.push_back(dec); rdy_q.push_back(1'($urandom_range(0, 1)));
        v = '0; v.src_a = 1; v.alu = exp_alu(funct_v);
        exp_q.push_back(v); rdy_q.push_back(1'($urandom_range(0, 1)));
        v = '0;
        if (TRAP_EN && !funct_ok(funct_v)) v.trap = 1;
        else begin v.reg_write = 1; v.reg_dst = 1; v.done = 1; end
        exp_q.push_back(v); rdy_q.push_back(1'($urandom_range(0, 1)));
      end
      6'b000100: begin
        exp_q.push_back(dec); rdy_q.push_back(1'($urandom_range(0, 1)));
        v = '0; v.src_a = 1; v.alu = 3'b110; v.pc_src = 2'b01; v.done = 1; v.pc_en = zero_v;
        exp_q.push_back(v); rdy_q.push_back(1'($urandom_range(0, 1)));
      end
      6'b001000: begin
        exp_q.push_back(dec); rdy_q.push_back(1'($urandom_range(0, 1)));
        v = '0; v.src_a = 1; v.src_b = 2'b10; v.alu = 3'b010;
        exp_q.push_back(v); rdy_q.push_back(1'($urandom_range(0, 1)));
        v = '0; v.reg_write = 1; v.done = 1;
        exp_q.push_back(v); rdy_q.push_back(1'($urandom_range(0, 1)));
      end
      6'b000010: begin
        exp_q.push_back(dec); rdy_q.push_back(1'($urandom_range(0, 1)));
        v = '0; v.pc_en = 1; v.pc_src = 2'b10; v.done = 1;
        exp_q.push_back(v); rdy_q.push_back(1'($urandom_range(0, 1)));
      end
      default: begin
        if (TRAP_EN) begin
          exp_q.push_back(dec); rdy_q.push_back(1'($urandom_range(0, 1)));
          v = '0; v.trap = 1;
          exp_q.push_back(v); rdy_q.push_back(1'($urandom_range(0, 1)));
        end else begin
          dec.done = 1;
          exp_q.push_back(dec); rdy_q.push_back(1'($urandom_range(0, 1)));
        end
      end
    endcase
    op = op_v; funct = funct_v; zero = zero_v;
    for (int i = 0; i < exp_q.size(); i++) begin
      mem_ready = rdy_q[i];
      @(negedge clk);
      total++;
      if (obs !== exp_q[i]) begin
        bad++;
        $display("FAIL %s cycle %0d: got %h want %h", tag, i, obs, exp_q[i]);
      end
      @(posedge clk); #1;
    end
    $display("instr %s op=%b funct=%b zero=%0d fwait=%0d mwait=%0d cycles=%0d",
             tag, op_v, funct_v, zero_v, fwait, mwait, exp_q.size());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (obs !== vec_t'(0)) begin
        bad++;
        $display("FAIL reset_outputs: got %h want 0", obs);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    op = 6'b000000; funct = 6'b100000; zero = 1'b0; mem_ready = 1'b1;
    do_reset();
    run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, "reset_then_add");
  endtask

  task automatic test_lw();
    run_instr(6'b100011, 6'b000000, 1'b0, 0, 0, "lw");
  endtask

  task automatic test_sw_wait();
    run_instr(6'b101011, 6'b000000, 1'b0, 0, 3, "sw_wait3");
  endtask

  task automatic test_beq();
    run_instr(6'b000100, 6'b000000, 1'b1, 0, 0, "beq_taken");
    run_instr(6'b000100, 6'b000000, 1'b0, 0, 0, "beq_not_taken");
  endtask

  task automatic test_rtype();
    run_instr(6'b000000, 6'b101010, 1'b0, 1, 0, "slt");
    run_instr(6'b000000, 6'b100010, 1'b0, 0, 0, "sub");
  endtask

  task automatic test_illegal();
    run_instr(6'b000000, 6'b111111, 1'b0, 0, 0, "bad_funct");
    if (TRAP_EN) do_reset();
    run_instr(6'b001101, 6'b000000, 1'b0, 0, 0, "bad_op");
    if (TRAP_EN) do_reset();
  endtask

  task automatic test_random();
    logic [5:0] ops[7];
    logic [5:0] fns[6];
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b001101};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
    for (int n = 0; n < 40; n++) begin
      logic [5:0] o, f;
      o = ops[$urandom_range(0, TRAP_EN ? 5 : 6)];
      f = fns[$urandom_range(0, TRAP_EN ? 4 : 5)];
      run_instr(o, f, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), "rand");
    end
  endtask

  task automatic test_reset_mid();
    op = 6'b100011; funct = 6'b000000; zero = 1'b0;
    mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    @(negedge clk);
    total++;
    if (!(mem_req === 1'b1 && iord === 1'b1 && reg_write === 1'b0)) begin
      bad++;
      $display("FAIL memread_before_rst: got req=%b iord=%b want req=1 iord=1", mem_req, iord);
    end
    #2 rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    total++;
    if (obs !== vec_t'(0)) begin
      bad++;
      $display("FAIL async_reset_outputs: got %h want 0", obs);
    end
    repeat (2) begin
      @(negedge clk);
      total++;
      if (reg_write !== 1'b0 || obs !== vec_t'(0)) begin
        bad++;
        $display("FAIL reset_hold: got %h want 0", obs);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    run_instr(6'b001000, 6'b000000, 1'b0, 0, 0, "addi_after_rst");
  endtask

  initial begin
    rst = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    test_reset();
    test_lw();
    test_sw_wait();
    test_beq();
    test_rtype();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
